md_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller that owns the HI/LO registers for the pipelined MIPS core.
- Accepts mult/multu/div/divu from the execute stage and iterates radix-2 over 32 cycles.
- Generates the pipeline stall for dependent HI/LO accesses and services mthi/mtlo/mfhi/mflo.
- Sits beside the ALU in the execute stage; its stall output is ORed into the hazard unit's stallF/stallD/stallE.

---
 rtl/md_sequencer_if.sv | 27 ++
 rtl/md_sequencer.sv | 161 ++++++++++++++++
 tb/tb_md_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer bundle: E-stage request, D-stage HI/LO read hint, HI/LO and status back.
interface md_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             mthiE;
  logic             mtloE;
  logic             mfhiloD;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE, mfhiloD,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE, mfhiloD,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/md_sequencer.sv
// Radix-2 multiply/divide controller owning HI/LO for the MIPS execute stage.
// Optional macro MD_EARLY_OUT_EN: multiplies finish once no multiplier bits remain.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  md_sequencer_if.slave mdBus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} mdStateT;

  mdStateT stateReg, stateNext;

  logic [CW-1:0]      counterReg;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               doneReg;
  logic               isDivReg, negResReg, negRemReg, divZeroReg;
  logic [2*WIDTH-1:0] mcandReg, prodReg;
  logic [WIDTH-1:0]   mplierReg;
  logic [WIDTH-1:0]   divisorReg, quoReg, remReg, dividendReg;

  logic               isSigned, startDiv, divByZero, zeroMplier;
  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] mulAcc, prodFinal;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divDiff, quoFinal, remFinal;
  logic               lastStep, earlyDone;

  // Operand conditioning: magnitudes for signed ops, raw values otherwise.
  assign isSigned  = ~mdBus.opE[0];
  assign startDiv  = mdBus.opE[1];
  assign absA      = (isSigned && mdBus.srcaE[WIDTH-1]) ? -mdBus.srcaE : mdBus.srcaE;
  assign absB      = (isSigned && mdBus.srcbE[WIDTH-1]) ? -mdBus.srcbE : mdBus.srcbE;
  assign divByZero = startDiv && (mdBus.srcbE == '0);

`ifdef MD_EARLY_OUT_EN
  assign zeroMplier = ~startDiv && (absB == '0);
  assign earlyDone  = ~isDivReg && (mplierReg[WIDTH-1:1] == '0);
`else
  assign zeroMplier = 1'b0;
  assign earlyDone  = 1'b0;
`endif

  // Multiply accumulates a left-shifting multiplicand so an early exit leaves a correct product.
  assign mulAcc = mplierReg[0] ? (prodReg + mcandReg) : prodReg;

  // Restoring divide: bring in the next dividend bit and subtract if the divisor fits.
  assign divShift = {remReg, quoReg[WIDTH-1]};
  assign divFits  = divShift >= {1'b0, divisorReg};
  assign divDiff  = divShift[WIDTH-1:0] - divisorReg;

  assign prodFinal = negResReg ? -prodReg : prodReg;
  assign quoFinal  = negResReg ? -quoReg : quoReg;
  assign remFinal  = negRemReg ? -remReg : remReg;

  assign lastStep = (counterReg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      IDLE: begin
        if (mdBus.startE) begin
          stateNext = (divByZero || zeroMplier) ? FIX : RUN;
        end
      end
      RUN: begin
        if (lastStep || earlyDone) begin
          stateNext = FIX;
        end
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counterReg  <= '0;
      hiReg       <= '0;
      loReg       <= '0;
      doneReg     <= 1'b0;
      isDivReg    <= 1'b0;
      negResReg   <= 1'b0;
      negRemReg   <= 1'b0;
      divZeroReg  <= 1'b0;
      mcandReg    <= '0;
      prodReg     <= '0;
      mplierReg   <= '0;
      divisorReg  <= '0;
      quoReg      <= '0;
      remReg      <= '0;
      dividendReg <= '0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (mdBus.startE) begin
            counterReg  <= '0;
            isDivReg    <= startDiv;
            negResReg   <= isSigned && (mdBus.srcaE[WIDTH-1] ^ mdBus.srcbE[WIDTH-1]);
            negRemReg   <= isSigned && mdBus.srcaE[WIDTH-1];
            divZeroReg  <= divByZero;
            mcandReg    <= {{WIDTH{1'b0}}, absA};
            prodReg     <= '0;
            mplierReg   <= absB;
            divisorReg  <= absB;
            quoReg      <= absA;
            remReg      <= '0;
            dividendReg <= mdBus.srcaE;
          end else begin
            if (mdBus.mthiE) hiReg <= mdBus.srcaE;
            if (mdBus.mtloE) loReg <= mdBus.srcaE;
          end
        end
        RUN: begin
          counterReg <= counterReg + CW'(1);
          if (isDivReg) begin
            quoReg <= {quoReg[WIDTH-2:0], divFits};
            remReg <= divFits ? divDiff : divShift[WIDTH-1:0];
          end else begin
            prodReg   <= mulAcc;
            mcandReg  <= mcandReg << 1;
            mplierReg <= mplierReg >> 1;
          end
        end
        FIX: begin
          doneReg <= 1'b1;
          if (divZeroReg) begin
            loReg <= '1;
            hiReg <= dividendReg;
          end else if (isDivReg) begin
            loReg <= quoFinal;
            hiReg <= remFinal;
          end else begin
            loReg <= prodFinal[WIDTH-1:0];
            hiReg <= prodFinal[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign mdBus.hi    = hiReg;
  assign mdBus.lo    = loReg;
  assign mdBus.done  = doneReg;
  assign mdBus.busy  = (stateReg != IDLE);
  assign mdBus.stall = mdBus.busy &
                       (mdBus.startE | mdBus.mthiE | mdBus.mtloE | mdBus.mfhiloD);
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: arithmetic results, latency, done/busy/stall and HI/LO moves.
module tb_md_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  md_sequencer_if #(.WIDTH(32)) mdBus ();

  md_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .mdBus (mdBus.slave)
  );

`ifdef MD_EARLY_OUT_EN
  localparam int SHORT_MUL_LAT = 3;
`else
  localparam int SHORT_MUL_LAT = 33;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits on negedges until busy falls; lat counts edges after the start edge.
  task automatic waitIdle(output int lat, output int busyCyc);
    lat = 0;
    busyCyc = 0;
    while (mdBus.busy && lat < 100) begin
      busyCyc++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("busy_timeout", 64'(lat), 64'(0));
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busyCyc, output logic donePulse);
    @(negedge clk);
    mdBus.startE = 1'b1;
    mdBus.opE    = op;
    mdBus.srcaE  = a;
    mdBus.srcbE  = b;
    @(negedge clk);
    mdBus.startE = 1'b0;
    waitIdle(lat, busyCyc);
    donePulse = mdBus.done;
    $display("[TB] op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h lat=%0d",
             op, a, b, mdBus.hi, mdBus.lo, lat);
    @(negedge clk);
    donePulse = donePulse & ~mdBus.done;
  endtask

  initial begin
    int   lat, busyCyc;
    logic donePulse, stallOk;

    mdBus.startE  = 1'b0;
    mdBus.opE     = 2'b00;
    mdBus.srcaE   = '0;
    mdBus.srcbE   = '0;
    mdBus.mthiE   = 1'b0;
    mdBus.mtloE   = 1'b0;
    mdBus.mfhiloD = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_hi", 64'(mdBus.hi), 64'h0);
    check("rst_lo", 64'(mdBus.lo), 64'h0);
    check("rst_busy", 64'(mdBus.busy), 64'h0);
    check("rst_done", 64'(mdBus.done), 64'h0);
    check("rst_stall", 64'(mdBus.stall), 64'h0);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busyCyc, donePulse);
    check("multu_max_hi", 64'(mdBus.hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(mdBus.lo), 64'h0000_0001);
    check("multu_max_lat", 64'(lat), 64'd33);
    check("multu_max_busy", 64'(busyCyc), 64'd33);
    check("multu_max_done", 64'(donePulse), 64'h1);

    runOp(2'b00, 32'hFFFF_FFF9, 32'd3, lat, busyCyc, donePulse);
    check("mult_neg_hi", 64'(mdBus.hi), 64'hFFFF_FFFF);
    check("mult_neg_lo", 64'(mdBus.lo), 64'hFFFF_FFEB);
    check("mult_neg_lat", 64'(lat), 64'(SHORT_MUL_LAT));

    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, lat, busyCyc, donePulse);
    check("div_neg_lo", 64'(mdBus.lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(mdBus.hi), 64'hFFFF_FFFF);
    check("div_neg_lat", 64'(lat), 64'd33);

    runOp(2'b10, 32'd5, 32'd0, lat, busyCyc, donePulse);
    check("div0_lo", 64'(mdBus.lo), 64'hFFFF_FFFF);
    check("div0_hi", 64'(mdBus.hi), 64'h5);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_done", 64'(donePulse), 64'h1);

    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, busyCyc, donePulse);
    check("div_ovf_lo", 64'(mdBus.lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(mdBus.hi), 64'h0);

    runOp(2'b01, 32'h1234_5678, 32'd3, lat, busyCyc, donePulse);
    check("multu_small_hi", 64'(mdBus.hi), 64'h0);
    check("multu_small_lo", 64'(mdBus.lo), 64'h369D_0368);
    check("multu_small_lat", 64'(lat), 64'(SHORT_MUL_LAT));

    @(negedge clk);
    mdBus.mthiE = 1'b1;
    mdBus.srcaE = 32'h1234;
    #1;
    check("mthi_stall", 64'(mdBus.stall), 64'h0);
    @(negedge clk);
    mdBus.mthiE = 1'b0;
    $display("[TB] mthi 0x1234 -> hi=0x%08h lo=0x%08h", mdBus.hi, mdBus.lo);
    check("mthi_hi", 64'(mdBus.hi), 64'h1234);
    check("mthi_lo", 64'(mdBus.lo), 64'h369D_0368);
    check("mthi_busy", 64'(mdBus.busy), 64'h0);
    check("mthi_done", 64'(mdBus.done), 64'h0);

    mdBus.mthiE = 1'b1;
    mdBus.mtloE = 1'b1;
    mdBus.srcaE = 32'hCAFE;
    @(negedge clk);
    mdBus.mthiE = 1'b0;
    mdBus.mtloE = 1'b0;
    $display("[TB] mthi+mtlo 0xCAFE -> hi=0x%08h lo=0x%08h", mdBus.hi, mdBus.lo);
    check("mtboth_hi", 64'(mdBus.hi), 64'hCAFE);
    check("mtboth_lo", 64'(mdBus.lo), 64'hCAFE);

    mdBus.startE = 1'b1;
    mdBus.mthiE  = 1'b1;
    mdBus.opE    = 2'b01;
    mdBus.srcaE  = 32'd2;
    mdBus.srcbE  = 32'd3;
    @(negedge clk);
    mdBus.startE = 1'b0;
    mdBus.mthiE  = 1'b0;
    check("startwins_hi_held", 64'(mdBus.hi), 64'hCAFE);
    check("startwins_busy", 64'(mdBus.busy), 64'h1);
    waitIdle(lat, busyCyc);
    $display("[TB] multu 2x3 with mthi -> hi=0x%08h lo=0x%08h", mdBus.hi, mdBus.lo);
    check("startwins_hi", 64'(mdBus.hi), 64'h0);
    check("startwins_lo", 64'(mdBus.lo), 64'h6);

    // Dependent-access stall with a second request held across the whole run.
    @(negedge clk);
    mdBus.startE = 1'b1;
    mdBus.opE    = 2'b01;
    mdBus.srcaE  = 32'h0001_0000;
    mdBus.srcbE  = 32'h8000_0000;
    @(negedge clk);
    mdBus.startE  = 1'b0;
    mdBus.mfhiloD = 1'b1;
    #1;
    check("stall_mfhilo", 64'(mdBus.stall), 64'h1);
    repeat (5) @(negedge clk);
    mdBus.startE = 1'b1;
    mdBus.mthiE  = 1'b1;
    mdBus.opE    = 2'b11;
    mdBus.srcaE  = 32'd100;
    mdBus.srcbE  = 32'd7;
    #1;
    stallOk = 1'b1;
    lat = 0;
    while (mdBus.busy && lat < 100) begin
      if (!mdBus.stall) stallOk = 1'b0;
      @(negedge clk);
      #1;
      lat++;
    end
    check("stall_timeout", 64'(lat < 100), 64'h1);
    check("stall_held", 64'(stallOk), 64'h1);
    check("stall_released", 64'(mdBus.stall), 64'h0);
    check("stall_first_hi", 64'(mdBus.hi), 64'h8000);
    check("stall_first_lo", 64'(mdBus.lo), 64'h0);
    check("stall_first_done", 64'(mdBus.done), 64'h1);
    $display("[TB] multu under stall -> hi=0x%08h lo=0x%08h", mdBus.hi, mdBus.lo);
    @(negedge clk);
    mdBus.startE  = 1'b0;
    mdBus.mthiE   = 1'b0;
    mdBus.mfhiloD = 1'b0;
    check("second_started", 64'(mdBus.busy), 64'h1);
    waitIdle(lat, busyCyc);
    $display("[TB] divu 100/7 after stall -> hi=0x%08h lo=0x%08h", mdBus.hi, mdBus.lo);
    check("divu_lo", 64'(mdBus.lo), 64'd14);
    check("divu_hi", 64'(mdBus.hi), 64'd2);

    @(negedge clk);
    mdBus.startE = 1'b1;
    mdBus.opE    = 2'b10;
    mdBus.srcaE  = 32'd1000;
    mdBus.srcbE  = 32'd3;
    @(negedge clk);
    mdBus.startE = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset mid-divide -> hi=0x%08h lo=0x%08h busy=%0d", mdBus.hi, mdBus.lo, mdBus.busy);
    check("abort_hi", 64'(mdBus.hi), 64'h0);
    check("abort_lo", 64'(mdBus.lo), 64'h0);
    check("abort_busy", 64'(mdBus.busy), 64'h0);
    @(negedge clk);
    check("abort_no_done", 64'(mdBus.done), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
